// File: rtl/accel_frame_rx.sv
// accel_frame_rx: 8N1 deserializer plus 2-byte packet assembler producing a 14-bit sample.
module accel_frame_rx #(
    parameter int unsigned BAUD_DIV = 868,
    parameter int unsigned HALF_DIV = 434,
    parameter int unsigned PKT_TMO  = 17360
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX_A,
    output logic [13:0] Xmeas,
    output logic        accel_vld,
    output logic        frm_err
);

    localparam int unsigned CNT_W = $clog2(BAUD_DIV);
    localparam int unsigned TMO_W = $clog2(PKT_TMO + 1);

    typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_e;
    typedef enum logic       {P_WAIT_HI, P_WAIT_LO}             pkt_state_e;

    logic             rx_meta_q, rx_s_q, rx_prev_q;
    logic [2:0]       arm_q;
    logic             fall_edge;

    bit_state_e       bit_state_q, bit_state_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_rdy_q, byte_rdy_d;
    logic             byte_err_q, byte_err_d;

    pkt_state_e       pkt_state_q, pkt_state_d;
    logic [5:0]       hi_q, hi_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [13:0]      xmeas_q, xmeas_d;
    logic             accel_vld_q, accel_vld_d;
    logic             frm_err_q, frm_err_d;

    // Two-flop synchronizer, edge-detect history and post-reset arming
    // (arm_q keeps the reset value of the sync chain from faking a falling edge).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            arm_q     <= 3'b000;
        end else begin
            rx_meta_q <= RX_A;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
            arm_q     <= {arm_q[1:0], 1'b1};
        end
    end

    assign fall_edge = arm_q[2] & rx_prev_q & ~rx_s_q;

    // Bit FSM state and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_state_q <= B_IDLE;
            baud_cnt_q  <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            byte_rdy_q  <= 1'b0;
            byte_err_q  <= 1'b0;
        end else begin
            bit_state_q <= bit_state_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            byte_rdy_q  <= byte_rdy_d;
            byte_err_q  <= byte_err_d;
        end
    end

    // Bit FSM next state: mid-bit sampling, LSB-first shift, stop-bit verdict.
    always_comb begin
        bit_state_d = bit_state_q;
        baud_cnt_d  = baud_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        byte_rdy_d  = 1'b0;
        byte_err_d  = 1'b0;
        case (bit_state_q)
            B_IDLE: begin
                if (fall_edge) begin
                    bit_state_d = B_START;
                    baud_cnt_d  = '0;
                end
            end
            B_START: begin
                if (baud_cnt_q == CNT_W'(HALF_DIV - 1)) begin
                    baud_cnt_d  = '0;
                    bit_idx_d   = '0;
                    bit_state_d = rx_s_q ? B_IDLE : B_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            B_DATA: begin
                if (baud_cnt_q == CNT_W'(BAUD_DIV - 1)) begin
                    baud_cnt_d = '0;
                    shift_d    = {rx_s_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        bit_state_d = B_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            B_STOP: begin
                if (baud_cnt_q == CNT_W'(BAUD_DIV - 1)) begin
                    baud_cnt_d  = '0;
                    byte_rdy_d  = rx_s_q;
                    byte_err_d  = ~rx_s_q;
                    bit_state_d = B_IDLE;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            default: bit_state_d = B_IDLE;
        endcase
    end

    // Packet FSM state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_state_q <= P_WAIT_HI;
            hi_q        <= '0;
            tmo_cnt_q   <= '0;
            xmeas_q     <= '0;
            accel_vld_q <= 1'b0;
            frm_err_q   <= 1'b0;
        end else begin
            pkt_state_q <= pkt_state_d;
            hi_q        <= hi_d;
            tmo_cnt_q   <= tmo_cnt_d;
            xmeas_q     <= xmeas_d;
            accel_vld_q <= accel_vld_d;
            frm_err_q   <= frm_err_d;
        end
    end

    // Packet FSM next state: pair high/low bytes, flag stop errors and inter-byte timeouts.
    always_comb begin
        pkt_state_d = pkt_state_q;
        hi_d        = hi_q;
        tmo_cnt_d   = tmo_cnt_q;
        xmeas_d     = xmeas_q;
        accel_vld_d = 1'b0;
        frm_err_d   = 1'b0;
        case (pkt_state_q)
            P_WAIT_HI: begin
                if (byte_rdy_q) begin
                    hi_d        = shift_q[5:0];
                    tmo_cnt_d   = '0;
                    pkt_state_d = P_WAIT_LO;
                end else if (byte_err_q) begin
                    frm_err_d = 1'b1;
                end
            end
            P_WAIT_LO: begin
                if (byte_rdy_q) begin
                    xmeas_d     = {hi_q, shift_q};
                    accel_vld_d = 1'b1;
                    pkt_state_d = P_WAIT_HI;
                end else if (byte_err_q) begin
                    frm_err_d   = 1'b1;
                    pkt_state_d = P_WAIT_HI;
                end else if ((tmo_cnt_q == TMO_W'(PKT_TMO)) && (bit_state_q == B_IDLE)) begin
                    frm_err_d   = 1'b1;
                    pkt_state_d = P_WAIT_HI;
                end else if (tmo_cnt_q != TMO_W'(PKT_TMO)) begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            default: pkt_state_d = P_WAIT_HI;
        endcase
    end

    assign Xmeas     = xmeas_q;
    assign accel_vld = accel_vld_q;
    assign frm_err   = frm_err_q;

endmodule

// File: tb/tb_accel_frame_rx.sv
// Bench for accel_frame_rx: directed and random serial traffic against a packet-level model.
module tb_accel_frame_rx;

    localparam int unsigned BAUD  = 32;
    localparam int unsigned HALF  = 16;
    localparam int unsigned TMO   = 640;
    localparam int          CLK_P = 10;
    localparam int          BIT_T = 320;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        RX_A  = 1'b1;
    logic [13:0] Xmeas;
    logic        accel_vld;
    logic        frm_err;

    int checks = 0;
    int errors = 0;

    int          vld_seen = 0;
    int          err_seen = 0;
    int          cyc      = 0;
    int          err_cyc  = 0;
    logic [13:0] prev_x   = '0;
    logic        prev_vld = 1'b0;
    logic        prev_err = 1'b0;

    // Packet-level reference model.
    int          exp_vld  = 0;
    int          exp_err  = 0;
    logic [13:0] exp_x    = '0;
    logic [7:0]  m_hi     = '0;
    bit          m_have_hi = 1'b0;

    accel_frame_rx #(.BAUD_DIV(BAUD), .HALF_DIV(HALF), .PKT_TMO(TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .RX_A      (RX_A),
        .Xmeas     (Xmeas),
        .accel_vld (accel_vld),
        .frm_err   (frm_err)
    );

    always #(CLK_P / 2) clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic void model_byte(input logic [7:0] b, input bit stop_ok);
        if (!stop_ok) begin
            exp_err++;
            m_have_hi = 1'b0;
        end else if (m_have_hi) begin
            exp_x     = {m_hi[5:0], b};
            exp_vld++;
            m_have_hi = 1'b0;
        end else begin
            m_hi      = b;
            m_have_hi = 1'b1;
        end
    endfunction

    function automatic void model_long_idle();
        if (m_have_hi) begin
            exp_err++;
            m_have_hi = 1'b0;
        end
    endfunction

    function automatic void model_reset();
        exp_x     = '0;
        m_have_hi = 1'b0;
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int bit_t);
        RX_A = 1'b0;
        #(bit_t);
        for (int i = 0; i < 8; i++) begin
            RX_A = b[i];
            #(bit_t);
        end
        RX_A = stop_ok;
        #(bit_t);
        RX_A = 1'b1;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_vld_cnt"}, 32'(vld_seen), 32'(exp_vld));
        check({tag, "_err_cnt"}, 32'(err_seen), 32'(exp_err));
        check({tag, "_xmeas"},   32'(Xmeas),    32'(exp_x));
    endtask

    task automatic packet(input string tag, input logic [7:0] hi, input logic [7:0] lo);
        send_byte(hi, 1'b1, BIT_T);
        model_byte(hi, 1'b1);
        send_byte(lo, 1'b1, BIT_T);
        model_byte(lo, 1'b1);
        #(4 * CLK_P);
        check_state(tag);
    endtask

    // Pulse monitor: counts strobes, checks exclusivity, width, and Xmeas update rule.
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (accel_vld) begin
                vld_seen++;
                check("vld_err_excl", 32'(frm_err), 32'd0);
                check("vld_width", 32'(prev_vld), 32'd0);
            end
            if (frm_err) begin
                err_seen++;
                err_cyc = cyc;
                check("err_width", 32'(prev_err), 32'd0);
            end
            if (Xmeas !== prev_x) check("xmeas_with_vld", 32'(accel_vld), 32'd1);
        end
        prev_x   = Xmeas;
        prev_vld = accel_vld;
        prev_err = frm_err;
    end

    initial begin
        int mark;
        int delta;
        int bit_t;
        int gap;
        logic [7:0] b;
        bit ok;

        // Reset values
        #(3 * CLK_P + 3);
        check("rst_xmeas", 32'(Xmeas), 32'd0);
        check("rst_vld",   32'(accel_vld), 32'd0);
        check("rst_err",   32'(frm_err), 32'd0);
        rst_n = 1'b1;
        #(10 * CLK_P);

        // Nominal packet and high-byte masking
        packet("nominal", 8'h12, 8'h34);
        check("nominal_value", 32'(Xmeas), 32'h1234);
        packet("mask1", 8'hD2, 8'h34);
        packet("mask2", 8'h3F, 8'hFF);
        check("mask2_value", 32'(Xmeas), 32'h3FFF);

        // Stop-bit error on the low byte
        send_byte(8'h05, 1'b1, BIT_T);
        model_byte(8'h05, 1'b1);
        send_byte(8'h66, 1'b0, BIT_T);
        model_byte(8'h66, 1'b0);
        #(2 * BIT_T);
        check_state("stoperr");
        packet("after_stoperr", 8'h01, 8'h02);
        check("after_stoperr_value", 32'(Xmeas), 32'h0102);

        // Inter-byte timeout and resync
        send_byte(8'h2A, 1'b1, BIT_T);
        model_byte(8'h2A, 1'b1);
        mark = cyc;
        #(TMO * CLK_P + 1000);
        model_long_idle();
        check_state("timeout");
        delta = err_cyc - mark;
        check("timeout_timing", 32'((delta >= 610) && (delta <= 650)), 32'd1);
        packet("after_timeout", 8'h01, 8'h80);
        check("after_timeout_value", 32'(Xmeas), 32'h0180);

        // Glitch shorter than half a bit
        RX_A = 1'b0;
        #(4 * CLK_P);
        RX_A = 1'b1;
        #(3 * BIT_T);
        check_state("glitch");
        packet("after_glitch", 8'h15, 8'hA7);

        // Random bytes with sender drift, small gaps and occasional stop errors
        for (int n = 0; n < 24; n++) begin
            b = 8'($urandom);
            ok = ($urandom_range(0, 7) != 0);
            case ($urandom_range(0, 2))
                0:       bit_t = 314;
                1:       bit_t = 320;
                default: bit_t = 326;
            endcase
            gap = int'($urandom_range(0, 3));
            if (!ok && gap == 0) gap = 1;
            send_byte(b, ok, bit_t);
            model_byte(b, ok);
            #(2 * CLK_P);
            check_state($sformatf("rand%0d", n));
            #(gap * bit_t);
        end
        #(30 * BIT_T);
        model_long_idle();
        check_state("rand_idle");

        // Asynchronous reset in the middle of a low byte, released while the line is low
        send_byte(8'h11, 1'b1, BIT_T);
        model_byte(8'h11, 1'b1);
        RX_A = 1'b0;
        #(5 * BIT_T + 7);
        rst_n = 1'b0;
        model_reset();
        #3;
        check("midrst_xmeas", 32'(Xmeas), 32'd0);
        check("midrst_vld",   32'(accel_vld), 32'd0);
        check("midrst_err",   32'(frm_err), 32'd0);
        #100;
        rst_n = 1'b1;
        #(3 * BIT_T);
        check_state("post_rst_low");
        RX_A = 1'b1;
        #(2 * BIT_T);
        check_state("post_rst_idle");
        packet("after_rst", 8'h02, 8'h03);
        check("after_rst_value", 32'(Xmeas), 32'h0203);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
